// File: rtl/fpu_writeback_unit_if.sv
// Bundles the writeback unit's request, decode-source and register-file
// signals. The master side drives the FPU/ALU requests and decode sources.
// The slave side is the writeback unit itself.
interface fpu_writeback_unit_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             fpu_valid_i;
   logic [5:0]       fpu_dest_i;
   logic [WIDTH-1:0] fpu_data_i;
   logic             alu_valid_i;
   logic [5:0]       alu_dest_i;
   logic [WIDTH-1:0] alu_data_i;
   logic [5:0]       src1_i;
   logic [5:0]       src2_i;
   logic             rf_we_o;
   logic [5:0]       rf_waddr_o;
   logic [WIDTH-1:0] rf_wdata_o;
   logic             pend_hazard_o;
   logic             stall_o;
   logic [CW-1:0]    count_o;
   logic             overflow_o;

   modport master (
      output fpu_valid_i, fpu_dest_i, fpu_data_i,
      output alu_valid_i, alu_dest_i, alu_data_i,
      output src1_i, src2_i,
      input  rf_we_o, rf_waddr_o, rf_wdata_o,
      input  pend_hazard_o, stall_o, count_o, overflow_o
   );

   modport slave (
      input  fpu_valid_i, fpu_dest_i, fpu_data_i,
      input  alu_valid_i, alu_dest_i, alu_data_i,
      input  src1_i, src2_i,
      output rf_we_o, rf_waddr_o, rf_wdata_o,
      output pend_hazard_o, stall_o, count_o, overflow_o
   );
endinterface

// File: rtl/fpu_writeback_unit.sv
// FPU/ALU writeback arbiter. It commits one register write per cycle with
// priority ALU > buffered FPU result > direct FPU bypass. FPU results that
// cannot write immediately are held in an in-order buffer.
module fpu_writeback_unit #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input logic                clk_i,
   input logic                rst_ni,
   fpu_writeback_unit_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [CW-1:0]    r_count;
   logic [DEPTH-1:0] r_validMem;
   logic [5:0]       r_destMem [DEPTH];
   logic [WIDTH-1:0] r_dataMem [DEPTH];
   logic             r_rfWe;
   logic [5:0]       r_rfWaddr;
   logic [WIDTH-1:0] r_rfWdata;
   logic             r_overflow;

   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_bypass;
   logic             w_pushReq;
   logic             w_push;
   logic             w_drop;
   logic             w_selValid;
   logic [5:0]       w_selDest;
   logic [WIDTH-1:0] w_selData;
   logic             w_hazard;

   // The buffer drains whenever the ALU is not claiming the port. An FPU
   // result skips the buffer only when nothing older is waiting, which keeps
   // results in order. A full buffer still accepts a result in a cycle that
   // also pops.
   always_comb begin
      w_empty   = (r_count == '0);
      w_full    = (r_count == CW'(DEPTH));
      w_pop     = !w_empty && !bus.alu_valid_i;
      w_bypass  = bus.fpu_valid_i && w_empty && !bus.alu_valid_i;
      w_pushReq = bus.fpu_valid_i && !w_bypass;
      w_push    = w_pushReq && (!w_full || w_pop);
      w_drop    = w_pushReq && w_full && !w_pop;
   end

   // Pick the single write for this cycle in priority order.
   always_comb begin
      w_selValid = 1'b0;
      w_selDest  = '0;
      w_selData  = '0;
      if (bus.alu_valid_i) begin
         w_selValid = 1'b1;
         w_selDest  = bus.alu_dest_i;
         w_selData  = bus.alu_data_i;
      end else if (w_pop) begin
         w_selValid = 1'b1;
         w_selDest  = r_destMem[r_head];
         w_selData  = r_dataMem[r_head];
      end else if (w_bypass) begin
         w_selValid = 1'b1;
         w_selDest  = bus.fpu_dest_i;
         w_selData  = bus.fpu_data_i;
      end
   end

   // Flag a decode source that matches any write that has not landed yet.
   // That covers buffered entries and the write currently on the port.
   always_comb begin
      w_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_validMem[i] && ((r_destMem[i] == bus.src1_i) || (r_destMem[i] == bus.src2_i))) begin
            w_hazard = 1'b1;
         end
      end
      if (r_rfWe && ((r_rfWaddr == bus.src1_i) || (r_rfWaddr == bus.src2_i))) begin
         w_hazard = 1'b1;
      end
   end

   // Buffer control state: pointers, occupancy and per-entry valid bits.
   // The clear happens before the set, so a full push-and-pop on the same
   // slot leaves that slot valid.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_validMem <= '0;
      end else begin
         if (w_pop) begin
            r_head             <= r_head + PW'(1);
            r_validMem[r_head] <= 1'b0;
         end
         if (w_push) begin
            r_tail             <= r_tail + PW'(1);
            r_validMem[r_tail] <= 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   // Entry payload storage. It needs no reset because the valid bits
   // qualify every read of it.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_destMem[r_tail] <= bus.fpu_dest_i;
         r_dataMem[r_tail] <= bus.fpu_data_i;
      end
   end

   // Register the selected write onto the register-file port. The address
   // and data hold their last value on idle cycles.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rfWe    <= 1'b0;
         r_rfWaddr <= '0;
         r_rfWdata <= '0;
      end else begin
         r_rfWe <= w_selValid;
         if (w_selValid) begin
            r_rfWaddr <= w_selDest;
            r_rfWdata <= w_selData;
         end
      end
   end

   // Sticky record of any FPU result lost to a full buffer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   assign bus.rf_we_o       = r_rfWe;
   assign bus.rf_waddr_o    = r_rfWaddr;
   assign bus.rf_wdata_o    = r_rfWdata;
   assign bus.count_o       = r_count;
   assign bus.overflow_o    = r_overflow;
   assign bus.pend_hazard_o = w_hazard;
   assign bus.stall_o       = (r_count >= CW'(DEPTH - 3));
endmodule

// File: doc/fpu_writeback_unit.md
FPU_WRITEBACK_UNIT -- requirements
Module: fpu_writeback_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width.
REQ-002 SHALL have parameter DEPTH, default 8, FPU result buffer entries (power of two, >= 4).
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port fpu_valid_i  input  1  FPU result retiring this cycle (from hazard tracker valid_o).
REQ-006 SHALL have port fpu_dest_i  input  6  destination register of FPU result (from hazard tracker dest_o).
REQ-007 SHALL have port fpu_data_i  input  WIDTH  FPU result data.
REQ-008 SHALL have port alu_valid_i  input  1  ALU writeback request this cycle.
REQ-009 SHALL have port alu_dest_i  input  6  ALU destination register.
REQ-010 SHALL have port alu_data_i  input  WIDTH  ALU result data.
REQ-011 SHALL have port src1_i, src2_i  input  6 each  source registers of instruction in decode.
REQ-012 SHALL have port rf_we_o  output  1  register file write enable.
REQ-013 SHALL have port rf_waddr_o  output  6  register file write address.
REQ-014 SHALL have port rf_wdata_o  output  WIDTH  register file write data.
REQ-015 SHALL have port pend_hazard_o  output  1  a source matches a not-yet-committed FPU/ALU write.
REQ-016 SHALL have port stall_o  output  1  FPU issue must stop.
REQ-017 SHALL have port count_o  output  clog2(DEPTH)+1  buffered FPU entries.
REQ-018 SHALL have port overflow_o  output  1  sticky: FPU result was dropped.

Function
REQ-019 SHALL select one write per cycle, priority: ALU > FIFO head > direct FPU bypass.
REQ-020 SHALL register the selected write into rf_we_o/rf_waddr_o/rf_wdata_o: 1-cycle latency from selection to port.
REQ-021 SHALL bypass fpu_valid_i directly (no enqueue) when FIFO empty and alu_valid_i low.
REQ-022 SHALL enqueue the FPU result at tail when fpu_valid_i high and not bypassed.
REQ-023 SHALL pop head when FIFO non-empty and alu_valid_i low; popped entry is the selected write.
REQ-024 SHALL permit push and pop in the same cycle, count unchanged, including when count == DEPTH.
REQ-025 SHALL, on push with count == DEPTH and no pop, drop the result, leave FIFO unchanged, set overflow_o until reset.
REQ-026 SHALL keep FIFO strictly in-order; pointers wrap modulo DEPTH.
REQ-027 SHALL drive rf_we_o low in any cycle after no source selected; rf_waddr_o/rf_wdata_o hold last value.
REQ-028 SHALL assert stall_o combinationally when count_o >= DEPTH-3 (covers 3 FPU results in flight).
REQ-029 SHALL assert pend_hazard_o combinationally when src1_i or src2_i equals dest of any valid FIFO entry, or equals rf_waddr_o while rf_we_o high.
REQ-030 SHALL, for ALU and FPU to same dest in same cycle, commit ALU first and FPU later (FPU value final).

Reset
REQ-031 SHALL on rst_ni low asynchronously clear: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, count_o=0, overflow_o=0, pointers=0, all entry valids=0.
REQ-032 SHALL give stall_o=0, pend_hazard_o=0 during and after reset until entries/writes exist.
REQ-033 SHALL, on reset mid-operation, discard buffered entries with no rf write issued.

Verification
REQ-034 SHALL verify bypass: FIFO empty, fpu_valid_i=1 dest=5 data=0x3F800000, ALU idle -> next cycle rf_we_o=1, waddr=5, wdata=0x3F800000, count_o=0.
REQ-035 SHALL verify conflict: ALU dest=2 and FPU dest=7 same cycle -> cycle+1 writes reg 2, cycle+2 writes reg 7; count_o 1 then 0.
REQ-036 SHALL verify stall/overflow: ALU held busy, 5 FPU pushes (DEPTH=8) -> stall_o=1 at count 5; 9th push -> overflow_o=1, count_o stays 8.
REQ-037 SHALL verify full simultaneous push/pop: count 8, ALU idle, fpu_valid_i=1 -> head written, new entry at tail, count_o stays 8, overflow_o=0.
REQ-038 SHALL verify hazard: entry dest=12 buffered, src1_i=12 -> pend_hazard_o=1; after its rf write cycle ends -> 0.
REQ-039 SHALL verify reset: 3 entries buffered, rst_ni low mid-cycle -> outputs zero immediately, no rf_we_o pulse after release.
